// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through dcache read-miss path.
// Holds the core config record, the miss FSM encoding and the line-compare width helper.
package wt_cache_pkg;

  typedef struct packed {
    int unsigned PLEN;
    int unsigned DCACHE_SET_ASSOC;
    int unsigned DCACHE_LINE_WIDTH;
    int unsigned DCACHE_OFFSET_WIDTH;
    int unsigned DCACHE_CL_IDX_WIDTH;
    int unsigned DCACHE_TAG_WIDTH;
    int unsigned CACHE_ID_WIDTH;
  } cva6_cfg_t;

  // 4 ways, 32-byte lines, 128 sets, 34-bit physical address.
  localparam cva6_cfg_t cva6_cfg_empty = '{
    PLEN:                34,
    DCACHE_SET_ASSOC:    4,
    DCACHE_LINE_WIDTH:   256,
    DCACHE_OFFSET_WIDTH: 5,
    DCACHE_CL_IDX_WIDTH: 7,
    DCACHE_TAG_WIDTH:    22,
    CACHE_ID_WIDTH:      4
  };

  typedef enum logic [1:0] {
    RD_IDLE      = 2'd0,
    RD_MEM_REQ   = 2'd1,
    RD_WAIT_RTRN = 2'd2
  } rd_miss_state_e;

  // Number of address bits that identify a cacheline (collision compare width).
  function automatic int unsigned cl_cmp_width(cva6_cfg_t cfg);
    return cfg.PLEN - cfg.DCACHE_OFFSET_WIDTH;
  endfunction

endpackage

// File: rtl/wt_dcache_way_sel.sv
// Refill way pick: lowest invalid way, else round-robin; one-hot out, combinational.
// The round-robin pointer only advances when a full set is actually allocated (upd_i).
module wt_dcache_way_sel #(
  parameter int unsigned Ways = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [Ways-1:0] vld_bits_i,
  input  logic            upd_i,
  output logic [Ways-1:0] way_o
);

  localparam int unsigned PtrW = (Ways > 1) ? $clog2(Ways) : 1;

  logic [PtrW-1:0] rr_q;
  logic            all_vld;

  assign all_vld = &vld_bits_i;

  always_comb begin
    way_o = '0;
    if (all_vld) begin
      way_o[rr_q] = 1'b1;
    end else begin
      // Scan high to low so the lowest invalid way is the one left standing.
      for (int i = Ways - 1; i >= 0; i--) begin
        if (!vld_bits_i[i]) begin
          way_o    = '0;
          way_o[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (upd_i && all_vld) begin
      rr_q <= (rr_q == PtrW'(Ways - 1)) ? '0 : rr_q + 1'b1;
    end
  end

endmodule

// File: rtl/wt_dcache_rd_miss_unit.sv
// Read-miss responder: one miss at a time, replay on write-buffer line collision, refill on return.
// Ack/replay are same-cycle; rtrn_vld pulses in the cycle the matching memory return arrives.
module wt_dcache_rd_miss_unit
  import wt_cache_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
  parameter int unsigned RdTxId  = 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     miss_req_i,
  output logic                                     miss_ack_o,
  output logic                                     miss_replay_o,
  input  logic [CVA6Cfg.PLEN-1:0]                  miss_paddr_i,
  input  logic                                     miss_nc_i,
  input  logic [2:0]                               miss_size_i,
  input  logic [CVA6Cfg.DCACHE_SET_ASSOC-1:0]      miss_vld_bits_i,
  input  logic [CVA6Cfg.CACHE_ID_WIDTH-1:0]        miss_id_i,
  output logic                                     miss_rtrn_vld_o,
  input  logic                                     wbuf_pend_vld_i,
  input  logic [CVA6Cfg.PLEN-1:0]                  wbuf_pend_paddr_i,
  output logic                                     mem_req_o,
  input  logic                                     mem_gnt_i,
  output logic [CVA6Cfg.PLEN-1:0]                  mem_paddr_o,
  output logic [2:0]                               mem_size_o,
  output logic                                     mem_nc_o,
  output logic [CVA6Cfg.CACHE_ID_WIDTH-1:0]        mem_id_o,
  input  logic                                     mem_rtrn_vld_i,
  input  logic [CVA6Cfg.CACHE_ID_WIDTH-1:0]        mem_rtrn_id_i,
  input  logic [CVA6Cfg.DCACHE_LINE_WIDTH-1:0]     mem_rtrn_data_i,
  output logic                                     wr_cl_vld_o,
  output logic [CVA6Cfg.DCACHE_SET_ASSOC-1:0]      wr_cl_we_o,
  output logic [CVA6Cfg.DCACHE_TAG_WIDTH-1:0]      wr_cl_tag_o,
  output logic [CVA6Cfg.DCACHE_CL_IDX_WIDTH-1:0]   wr_cl_idx_o,
  output logic [CVA6Cfg.DCACHE_LINE_WIDTH-1:0]     wr_cl_data_o
);

  localparam int unsigned Plen = CVA6Cfg.PLEN;
  localparam int unsigned Ways = CVA6Cfg.DCACHE_SET_ASSOC;
  localparam int unsigned OffW = CVA6Cfg.DCACHE_OFFSET_WIDTH;
  localparam int unsigned IdxW = CVA6Cfg.DCACHE_CL_IDX_WIDTH;
  localparam int unsigned TagW = CVA6Cfg.DCACHE_TAG_WIDTH;
  localparam int unsigned IdW  = CVA6Cfg.CACHE_ID_WIDTH;
  localparam int unsigned CmpW = cl_cmp_width(CVA6Cfg);

  typedef struct packed {
    logic [Plen-1:0] paddr;
    logic [2:0]      size;
    logic            nc;
    logic [Ways-1:0] way;
  } miss_t;

  rd_miss_state_e  state_q;
  miss_t           miss_q;
  logic [Ways-1:0] way_pick;
  logic [CmpW-1:0] miss_cl, wbuf_cl;
  logic            idle_req, collision, rtrn_hit;
  logic            unused_bits;

  // Requester ID is fixed to RdTxId by construction; low wbuf address bits don't affect line match.
  assign unused_bits = ^{miss_id_i, wbuf_pend_paddr_i[OffW-1:0]};

  assign miss_cl   = miss_paddr_i[Plen-1:OffW];
  assign wbuf_cl   = wbuf_pend_paddr_i[Plen-1:OffW];
  assign collision = wbuf_pend_vld_i && (miss_cl == wbuf_cl);
  assign idle_req  = !rst_i && (state_q == RD_IDLE) && miss_req_i;
  assign rtrn_hit  = (state_q == RD_WAIT_RTRN) && mem_rtrn_vld_i && (mem_rtrn_id_i == IdW'(RdTxId));

  assign miss_replay_o   = idle_req && collision;
  assign miss_ack_o      = idle_req && !collision;
  assign miss_rtrn_vld_o = !rst_i && rtrn_hit;
  assign wr_cl_vld_o     = miss_rtrn_vld_o && !miss_q.nc;
  assign mem_req_o       = !rst_i && (state_q == RD_MEM_REQ);

  assign mem_paddr_o  = miss_q.paddr;
  assign mem_size_o   = miss_q.size;
  assign mem_nc_o     = miss_q.nc;
  assign mem_id_o     = IdW'(RdTxId);
  assign wr_cl_we_o   = miss_q.way;
  assign wr_cl_tag_o  = miss_q.paddr[Plen-1 -: TagW];
  assign wr_cl_idx_o  = miss_q.paddr[OffW +: IdxW];
  assign wr_cl_data_o = mem_rtrn_data_i;

  wt_dcache_way_sel #(
    .Ways (Ways)
  ) i_way_sel (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .vld_bits_i (miss_vld_bits_i),
    .upd_i      (miss_ack_o && !miss_nc_i),
    .way_o      (way_pick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RD_IDLE;
      miss_q  <= '0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (miss_ack_o) begin
            miss_q.paddr <= miss_nc_i ? miss_paddr_i : {miss_paddr_i[Plen-1:OffW], {OffW{1'b0}}};
            miss_q.size  <= miss_size_i;
            miss_q.nc    <= miss_nc_i;
            miss_q.way   <= way_pick;
            state_q      <= RD_MEM_REQ;
          end
        end
        RD_MEM_REQ: begin
          if (mem_gnt_i) state_q <= RD_WAIT_RTRN;
        end
        RD_WAIT_RTRN: begin
          if (rtrn_hit) state_q <= RD_IDLE;
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

endmodule
